// File: rtl/spi_shift.sv
// SPI shift engine: serialises a right-justified write word onto mosi and deserialises
// miso into rd_data, following CS/SCK edges produced by an external timing stage.
module spi_shift (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cpol,
    input  logic        cpha,
    input  logic [1:0]  w_r_mode,
    input  logic [5:0]  wr_width,
    input  logic [5:0]  rd_width,
    input  logic [31:0] wr_data,
    input  logic        cs,
    input  logic        sck,
    input  logic        miso,
    output logic        mosi,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        done
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT, FINISH} state_t;

    state_t            state;
    logic              sck_d;
    logic              cs_d;
    logic [6:0]        cnt;
    logic [6:0]        wr_left;
    logic [DATA_W-1:0] wr_shift;
    logic [DATA_W-1:0] rd_shift;

    logic              lead_edge;
    logic              trail_edge;
    logic              sample_edge;
    logic              shift_edge;
    logic              cs_fall;
    logic              cs_rise;
    logic              has_write;
    logic              has_read;
    logic [6:0]        wr_w7;
    logic [6:0]        rd_w7;
    logic [6:0]        data_tot;
    logic [6:0]        cnt_nxt;
    logic              in_wr_phase;
    logic              in_rd_phase;
    logic [6:0]        align_sh;
    logic [DATA_W-1:0] wr_aligned;

    always_comb begin
        lead_edge   = (sck_d == cpol) && (sck != cpol);
        trail_edge  = (sck_d != cpol) && (sck == cpol);
        sample_edge = cpha ? trail_edge : lead_edge;
        shift_edge  = cpha ? lead_edge : trail_edge;
        cs_fall     = cs_d && !cs;
        cs_rise     = !cs_d && cs;
        has_write   = (w_r_mode != 2'b00);
        has_read    = (w_r_mode != 2'b01);
        wr_w7       = {1'b0, wr_width};
        rd_w7       = {1'b0, rd_width};
        case (w_r_mode)
            2'b00:   data_tot = rd_w7;
            2'b01:   data_tot = wr_w7;
            default: data_tot = wr_w7 + rd_w7;
        endcase
        cnt_nxt     = cnt + 7'd1;
        in_wr_phase = has_write && (cnt < wr_w7);
        in_rd_phase = (w_r_mode == 2'b00) || (w_r_mode[1] && (cnt >= wr_w7));
        // Left-align the write word so the first bit to send always sits in the MSB.
        align_sh    = 7'd32 - wr_w7;
        wr_aligned  = wr_data << align_sh;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sck_d    <= cpol;
            cs_d     <= 1'b1;
            mosi     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            wr_left  <= '0;
            wr_shift <= '0;
            rd_shift <= '0;
        end else begin
            sck_d    <= sck;
            cs_d     <= cs;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            if (!en) begin
                state    <= IDLE;
                mosi     <= 1'b0;
                cnt      <= '0;
                wr_left  <= '0;
                wr_shift <= '0;
                rd_shift <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARMED;
                        mosi  <= 1'b0;
                    end
                    ARMED: begin
                        if (cs_fall) begin
                            state    <= SHIFT;
                            cnt      <= '0;
                            rd_shift <= '0;
                            // With cpha=0 the first bit must already be on the line
                            // before the first (sampling) lead edge.
                            if (has_write && !cpha) begin
                                mosi     <= wr_aligned[DATA_W-1];
                                wr_shift <= wr_aligned << 1;
                                wr_left  <= wr_w7 - 7'd1;
                            end else begin
                                mosi     <= 1'b0;
                                wr_shift <= wr_aligned;
                                wr_left  <= has_write ? wr_w7 : 7'd0;
                            end
                        end
                    end
                    SHIFT: begin
                        if (cs_rise) begin
                            state <= IDLE;
                            mosi  <= 1'b0;
                        end else if (cnt >= data_tot) begin
                            state <= FINISH;
                            mosi  <= 1'b0;
                        end else if (sample_edge) begin
                            cnt <= cnt_nxt;
                            if (in_rd_phase) begin
                                rd_shift <= {rd_shift[DATA_W-2:0], miso};
                            end
                            if (in_wr_phase && (cnt_nxt == wr_w7)) begin
                                mosi <= 1'b0;
                            end
                            if (cnt_nxt == data_tot) begin
                                state <= FINISH;
                            end
                        end else if (shift_edge) begin
                            if (wr_left != 7'd0) begin
                                mosi     <= wr_shift[DATA_W-1];
                                wr_shift <= wr_shift << 1;
                                wr_left  <= wr_left - 7'd1;
                            end else begin
                                mosi <= 1'b0;
                            end
                        end
                    end
                    FINISH: begin
                        mosi <= 1'b0;
                        if (cs_rise) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            if (has_read) begin
                                rd_data  <= rd_shift;
                                rd_valid <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_shift.sv
// Directed bench for spi_shift: a table of complete transfers plus hand-written
// abort, early-termination and mid-transfer reset sequences.
module tb_spi_shift;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic [1:0]  w_r_mode = 2'b00;
    logic [5:0]  wr_width = 6'd8;
    logic [5:0]  rd_width = 6'd8;
    logic [31:0] wr_data = '0;
    logic        cs = 1'b1;
    logic        sck = 1'b0;
    logic        miso = 1'b0;
    logic        mosi;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;

    spi_shift dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cpol(cpol), .cpha(cpha),
        .w_r_mode(w_r_mode), .wr_width(wr_width), .rd_width(rd_width),
        .wr_data(wr_data), .cs(cs), .sck(sck), .miso(miso), .mosi(mosi),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        cpol;
        logic        cpha;
        logic [5:0]  wrw;
        logic [5:0]  rdw;
        logic [31:0] wdat;
        logic [31:0] rdat_in;
        logic [63:0] exp_mosi;
        logic [31:0] exp_rd;
        int          exp_vld;
    } vec_t;

    vec_t        vecs[7];
    int          checks = 0;
    int          failures = 0;
    int          done_cnt;
    int          vld_cnt;
    int          coinc_cnt;
    logic [63:0] seq;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (done) done_cnt++;
        if (rd_valid) vld_cnt++;
        if (done && rd_valid) coinc_cnt++;
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    // Plays the CS/SCK timing stage and the SPI slave for up to nbits bits; a complete
    // transfer also raises cs and waits for the completion pulses.
    task automatic run_xfer(input vec_t v, input int nbits, output logic [63:0] mosi_seq);
        int   tot;
        int   rd_start;
        int   n;
        logic bit_i;
        tot      = (v.mode == 2'b00) ? int'(v.rdw) :
                   (v.mode == 2'b01) ? int'(v.wrw) : int'(v.wrw) + int'(v.rdw);
        rd_start = (v.mode == 2'b00) ? 0 : int'(v.wrw);
        n        = (nbits < tot) ? nbits : tot;
        mosi_seq = '0;
        done_cnt = 0;
        vld_cnt  = 0;
        coinc_cnt = 0;
        en       = 1'b0;
        cs       = 1'b1;
        miso     = 1'b0;
        w_r_mode = v.mode;
        cpol     = v.cpol;
        cpha     = v.cpha;
        wr_width = v.wrw;
        rd_width = v.rdw;
        wr_data  = v.wdat;
        sck      = v.cpol;
        hold(2);
        en = 1'b1;
        hold(3);
        cs = 1'b0;
        hold(2);
        for (int i = 0; i < n; i++) begin
            if (v.mode != 2'b01 && i >= rd_start)
                bit_i = v.rdat_in[int'(v.rdw) - 1 - (i - rd_start)];
            else
                bit_i = 1'b1;
            if (!v.cpha) begin
                miso = bit_i;
                sck = ~v.cpol;
                mosi_seq = {mosi_seq[62:0], mosi};
                hold(2);
                sck = v.cpol;
                hold(2);
            end else begin
                sck = ~v.cpol;
                hold(2);
                miso = bit_i;
                sck = v.cpol;
                mosi_seq = {mosi_seq[62:0], mosi};
                hold(2);
            end
        end
        if (nbits >= tot) begin
            cs = 1'b1;
            hold(4);
        end
    endtask

    initial begin
        //         mode   cpol  cpha  wrw    rdw    wdat          rdat_in       exp_mosi          exp_rd        vld
        vecs[0] = '{2'b01, 1'b0, 1'b0, 6'd8,  6'd8,  32'h0000_00A5, 32'h0,        64'hA5,           32'h0,        0};
        vecs[1] = '{2'b00, 1'b1, 1'b1, 6'd8,  6'd12, 32'hFFFF_FFFF, 32'hABC,      64'h0,            32'h0000_0ABC, 1};
        vecs[2] = '{2'b10, 1'b0, 1'b1, 6'd8,  6'd16, 32'h0000_009F, 32'h1234,     64'h9F_0000,      32'h0000_1234, 1};
        vecs[3] = '{2'b00, 1'b1, 1'b0, 6'd8,  6'd32, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 64'h0,           32'hDEAD_BEEF, 1};
        vecs[4] = '{2'b11, 1'b1, 1'b0, 6'd4,  6'd4,  32'hFFFF_FFFB, 32'h6,        64'hB0,           32'h0000_0006, 1};
        vecs[5] = '{2'b01, 1'b1, 1'b1, 6'd32, 6'd8,  32'h8000_0001, 32'h0,        64'h8000_0001,    32'h0000_0006, 0};
        vecs[6] = '{2'b10, 1'b0, 1'b0, 6'd1,  6'd1,  32'h0000_0003, 32'h1,        64'h2,            32'h0000_0001, 1};

        done_cnt = 0;
        vld_cnt = 0;
        coinc_cnt = 0;
        rst_n = 1'b0;
        hold(3);
        check("reset_mosi", 64'(mosi), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        hold(2);

        for (int k = 0; k < 7; k++) begin
            run_xfer(vecs[k], 1000, seq);
            check($sformatf("v%0d_mosi_seq", k), seq, vecs[k].exp_mosi);
            check($sformatf("v%0d_rd_data", k), 64'(rd_data), 64'(vecs[k].exp_rd));
            check($sformatf("v%0d_done_pulses", k), 64'(done_cnt), 64'd1);
            check($sformatf("v%0d_rd_valid_pulses", k), 64'(vld_cnt), 64'(vecs[k].exp_vld));
            check($sformatf("v%0d_valid_with_done", k), 64'(coinc_cnt), 64'(vecs[k].exp_vld));
            check($sformatf("v%0d_mosi_idle", k), 64'(mosi), 64'd0);
        end

        // en dropped after 5 of 16 write bits while mosi is driving a 1
        begin
            vec_t va;
            va = '{2'b01, 1'b0, 1'b0, 6'd16, 6'd8, 32'h0000_FFFF, 32'h0, 64'h0, 32'h0, 0};
            run_xfer(va, 5, seq);
            check("abort_mosi_before", 64'(mosi), 64'd1);
            check("abort_seq_before", seq, 64'h1F);
            en = 1'b0;
            step();
            check("abort_mosi_after", 64'(mosi), 64'd0);
            sck = 1'b0;
            cs = 1'b1;
            hold(4);
            check("abort_no_done", 64'(done_cnt), 64'd0);
            check("abort_no_rd_valid", 64'(vld_cnt), 64'd0);
            check("abort_rd_held", 64'(rd_data), 64'h1);
        end

        run_xfer(vecs[3], 1000, seq);
        check("post_abort_rd_data", 64'(rd_data), 64'hDEAD_BEEF);
        check("post_abort_done", 64'(done_cnt), 64'd1);
        check("post_abort_rd_valid", 64'(vld_cnt), 64'd1);

        // cs raised after 3 of 16 read bits with en still high
        begin
            vec_t ve;
            ve = '{2'b00, 1'b0, 1'b0, 6'd8, 6'd16, 32'h0, 32'h5555, 64'h0, 32'h0, 0};
            run_xfer(ve, 3, seq);
            cs = 1'b1;
            hold(4);
            check("early_cs_no_done", 64'(done_cnt), 64'd0);
            check("early_cs_no_rd_valid", 64'(vld_cnt), 64'd0);
            check("early_cs_rd_held", 64'(rd_data), 64'hDEAD_BEEF);
        end

        // reset pulse in the middle of a write-then-read transfer
        begin
            vec_t vr;
            vr = '{2'b10, 1'b0, 1'b0, 6'd8, 6'd8, 32'h0000_00FF, 32'h0, 64'h0, 32'h0, 0};
            run_xfer(vr, 3, seq);
            check("rst_mid_mosi_before", 64'(mosi), 64'd1);
            rst_n = 1'b0;
            step();
            check("rst_mid_mosi", 64'(mosi), 64'd0);
            check("rst_mid_rd_data", 64'(rd_data), 64'd0);
            check("rst_mid_rd_valid", 64'(rd_valid), 64'd0);
            check("rst_mid_done", 64'(done), 64'd0);
            rst_n = 1'b1;
            hold(2);
            sck = 1'b0;
            cs = 1'b1;
            hold(4);
            check("rst_mid_no_done_after", 64'(done_cnt), 64'd0);
            check("rst_mid_no_valid_after", 64'(vld_cnt), 64'd0);
        end

        run_xfer(vecs[4], 1000, seq);
        check("post_reset_mosi_seq", seq, 64'hB0);
        check("post_reset_rd_data", 64'(rd_data), 64'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_shift.md
SPI_SHIFT -- requirements
Module: spi_shift

Interface
REQ-001 Parameters: none; width fixed at 32 bits per direction.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 en  input  1  transfer enable, same signal that drives the CS/SCK timing stage; low aborts and clears.
REQ-005 cpol  input  1  SCK idle level.
REQ-006 cpha  input  1  0: sample on leading edges; 1: sample on trailing edges.
REQ-007 w_r_mode  input  2  00 read-only, 01 write-only, 10 write-then-read, 11 treated as 10.
REQ-008 wr_width  input  6  write bit count, legal 1..32.
REQ-009 rd_width  input  6  read bit count, legal 1..32.
REQ-010 wr_data  input  32  write word, right-justified, sent MSB first (bit wr_width-1 first).
REQ-011 cs  input  1  chip select from the CS/SCK timing stage, active low.
REQ-012 sck  input  1  serial clock from the CS/SCK timing stage, synchronous to clk.
REQ-013 miso  input  1  serial read data.
REQ-014 mosi  output  1  serial write data, registered.
REQ-015 rd_data  output  32  read word, right-justified, first received bit most significant.
REQ-016 rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-017 done  output  1  one-cycle pulse, transfer complete.

Function
REQ-018 sck_d, cs_d SHALL be one-cycle registered copies; lead edge = sck_d==cpol && sck!=cpol; trail edge = sck_d!=cpol && sck==cpol.
REQ-019 Sample edge = lead edge if cpha=0, trail edge if cpha=1; shift edge = the other edge.
REQ-020 States: IDLE, ARMED, SHIFT, FINISH; encoding free.
REQ-021 IDLE -> ARMED when en=1; ARMED -> SHIFT on cs fall (cs_d=1, cs=0); SHIFT -> FINISH when sample count equals data_tot; FINISH -> IDLE on cs rise (cs_d=0, cs=1), with done pulsed in that cycle.
REQ-022 data_tot = rd_width (00), wr_width (01), wr_width+rd_width (10/11), 7-bit unsigned.
REQ-023 On the ARMED->SHIFT transition: latch wr_data into wr_shift, clear 7-bit sample counter and rd_shift.
REQ-024 Write phase = sample indices 0..wr_width-1 in modes 01/10; read phase = indices 0..rd_width-1 (mode 00) or wr_width..data_tot-1 (mode 10).
REQ-025 cpha=0: mosi SHALL present wr_data[wr_width-1] in the cycle after cs fall; the next bit is presented one cycle after each shift edge.
REQ-026 cpha=1: mosi SHALL present the next write bit one cycle after each lead edge, starting with wr_data[wr_width-1] on the first lead edge.
REQ-027 mosi SHALL be 0 outside the write phase, in mode 00, and after the last write bit's sample edge.
REQ-028 Each sample edge in SHIFT SHALL increment the sample counter; in the read phase rd_shift <= {rd_shift[30:0], miso} using miso in the detection cycle.
REQ-029 Sample edges in ARMED, FINISH, or IDLE SHALL be ignored; shift edges with no bits remaining SHALL leave mosi at 0.
REQ-030 On the done cycle in modes 00/10/11: rd_data <= rd_shift, rd_valid=1; in mode 01, rd_valid stays 0 and rd_data holds its value.
REQ-031 Inputs cpol, cpha, w_r_mode, and widths SHALL be stable from en rise to done; wr_data is captured only at cs fall.
REQ-032 en=0 in any state SHALL return to IDLE next cycle, set mosi=0, and clear counters; no done/rd_valid is generated. rd_data holds its value.
REQ-033 cs rise while in SHIFT (early termination) SHALL go to IDLE without done or rd_valid.
REQ-034 Widths of 0 or >32 are illegal; behaviour is undefined but SHALL NOT lock up (en=0 recovers).

Reset
REQ-035 rst_n=0 SHALL force state IDLE, mosi=0, rd_data=0, rd_valid=0, done=0, counters/shift registers=0, sck_d=cpol, cs_d=1.
REQ-036 Reset SHALL override en and any in-flight transfer in the same cycle.

Verification
REQ-037 Mode 01, cpol=0 cpha=0, wr_width=8, wr_data=0xA5 -> mosi sampled on rising sck = 1,0,1,0,0,1,0,1; done one pulse at cs rise; rd_valid never.
REQ-038 Mode 00, cpol=1 cpha=1, rd_width=12, miso pattern 0xABC MSB first -> rd_data=0x00000ABC, rd_valid and done coincident one cycle.
REQ-039 Mode 10, cpol=0 cpha=1, wr_width=8 wr_data=0x9F, rd_width=16 miso 0x1234 -> mosi 0x9F then 0 for 16 bits, rd_data=0x00001234.
REQ-040 Mode 00, cpol=1 cpha=0, rd_width=32, miso=0xDEADBEEF -> rd_data=0xDEADBEEF, 32 samples counted.
REQ-041 en dropped mid-transfer after 5 of 16 bits -> IDLE next cycle, mosi=0, no done/rd_valid, rd_data unchanged; next full transfer correct.
REQ-042 rst_n asserted mid-transfer -> all outputs at reset values next cycle; cs rise afterwards produces no done.
